// File: rtl/packet_scheduler.sv
// HDMI data island packet slot scheduler: arbitrates the packet sources once per
// 32-cycle slot and holds the chosen header/subpackets for the whole slot.
module packet_scheduler #(
    parameter int AUDIO_PENDING_MAX = 3,
    parameter bit SPD_ENABLE        = 1'b1
) (
    input  logic                clk_pixel,
    input  logic                reset_n,
    input  logic                slot_start,
    input  logic                frame_start,
    input  logic                audio_tick,
    input  logic                acr_tick,
    input  logic [23:0]         audio_header,
    input  logic [23:0]         acr_header,
    input  logic [23:0]         avi_header,
    input  logic [23:0]         aif_header,
    input  logic [23:0]         spd_header,
    input  logic [3:0][55:0]    audio_sub,
    input  logic [3:0][55:0]    acr_sub,
    input  logic [3:0][55:0]    avi_sub,
    input  logic [3:0][55:0]    aif_sub,
    input  logic [3:0][55:0]    spd_sub,
    output logic [23:0]         header,
    output logic [3:0][55:0]    sub,
    output logic [2:0]          packet_type,
    output logic                slot_active,
    output logic                audio_ack,
    output logic                slot_overrun,
    output logic                audio_overflow
);
    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [2:0] AMAX = 3'(AUDIO_PENDING_MAX);

    state_t          state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [2:0]      audio_cnt_q, audio_cnt_d;
    logic            acr_q, acr_d, avi_q, avi_d, aif_q, aif_d, spd_q, spd_d;
    logic [23:0]     header_q, header_d;
    logic [3:0][55:0] sub_q, sub_d;
    logic [2:0]      type_q, type_d;
    logic            ack_q, ack_d, ovr_q, ovr_d, ovf_q, ovf_d;
    logic            select, spd_set;

    assign spd_set = frame_start && SPD_ENABLE;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovr_d   = ovr_q;
        select  = 1'b0;
        case (state_q)
            IDLE: begin
                if (slot_start) begin
                    select  = 1'b1;
                    state_d = SEND;
                    cnt_d   = 5'd0;
                end
            end
            SEND: begin
                if (cnt_q == 5'd31) begin
                    cnt_d = 5'd0;
                    if (slot_start) select = 1'b1;
                    else            state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                    if (slot_start) ovr_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Requests arriving in the selection cycle take part in that selection.
    always_comb begin
        header_d = header_q;
        sub_d    = sub_q;
        type_d   = type_q;
        ack_d    = 1'b0;
        if (select) begin
            if (audio_cnt_q != 3'd0 || audio_tick) begin
                header_d = audio_header; sub_d = audio_sub; type_d = 3'd1; ack_d = 1'b1;
            end else if (acr_q || acr_tick) begin
                header_d = acr_header;   sub_d = acr_sub;   type_d = 3'd2;
            end else if (avi_q || frame_start) begin
                header_d = avi_header;   sub_d = avi_sub;   type_d = 3'd3;
            end else if (aif_q || frame_start) begin
                header_d = aif_header;   sub_d = aif_sub;   type_d = 3'd4;
            end else if (spd_q || spd_set) begin
                header_d = spd_header;   sub_d = spd_sub;   type_d = 3'd5;
            end else begin
                header_d = 24'h000000;   sub_d = '0;        type_d = 3'd0;
            end
        end
    end

    // A new request on the same cycle its flag is consumed keeps the flag set.
    always_comb begin
        audio_cnt_d = audio_cnt_q;
        ovf_d       = ovf_q;
        case ({audio_tick, select && type_d == 3'd1})
            2'b10: begin
                if (audio_cnt_q == AMAX) ovf_d = 1'b1;
                else                     audio_cnt_d = audio_cnt_q + 3'd1;
            end
            2'b01:   audio_cnt_d = audio_cnt_q - 3'd1;
            default: audio_cnt_d = audio_cnt_q;
        endcase
        acr_d = acr_tick    || (acr_q && !(select && type_d == 3'd2));
        avi_d = frame_start || (avi_q && !(select && type_d == 3'd3));
        aif_d = frame_start || (aif_q && !(select && type_d == 3'd4));
        spd_d = spd_set     || (spd_q && !(select && type_d == 3'd5));
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= 5'd0;
            audio_cnt_q <= 3'd0;
            acr_q       <= 1'b0;
            avi_q       <= 1'b0;
            aif_q       <= 1'b0;
            spd_q       <= 1'b0;
            header_q    <= 24'h000000;
            sub_q       <= '0;
            type_q      <= 3'd0;
            ack_q       <= 1'b0;
            ovr_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            audio_cnt_q <= audio_cnt_d;
            acr_q       <= acr_d;
            avi_q       <= avi_d;
            aif_q       <= aif_d;
            spd_q       <= spd_d;
            header_q    <= header_d;
            sub_q       <= sub_d;
            type_q      <= type_d;
            ack_q       <= ack_d;
            ovr_q       <= ovr_d;
            ovf_q       <= ovf_d;
        end
    end

    assign header         = header_q;
    assign sub            = sub_q;
    assign packet_type    = type_q;
    assign slot_active    = (state_q == SEND);
    assign audio_ack      = ack_q;
    assign slot_overrun   = ovr_q;
    assign audio_overflow = ovf_q;
endmodule
